// File: rtl/t03_mem_arbiter.sv
// Round-robin arbiter granting NUM_CH requesters one memory transaction at a time.
// Each grant runs IDLE -> BUSY (strobe until ack or timeout) -> DONE (one-cycle pulse).
module t03_mem_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    input  logic                     ack,
    input  logic [DATA_W-1:0]        dataOut,
    output logic                     read,
    output logic                     write,
    output logic [ADDR_W-1:0]        address,
    output logic [DATA_W-1:0]        data,
    output logic [NUM_CH-1:0]        done_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [NUM_CH-1:0]        stall_o,
    output logic                     timeout_o,
    output logic                     busy
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick;
    logic          found;
    logic [CW-1:0] cnt;
    logic          abort;
    logic          tmo_hit;

    // First requester found scanning upward from rr_ptr with wrap.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req_i[(int'(rr_ptr) + k) % NUM_CH]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    assign tmo_hit = (TIMEOUT > 0) && (cnt == TLAST);
    assign stall_o = req_i & ~done_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            cnt       <= '0;
            abort     <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            address   <= '0;
            data      <= '0;
            done_o    <= '0;
            rdata_o   <= '0;
            timeout_o <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_o    <= '0;
                    timeout_o <= 1'b0;
                    if (found) begin
                        state   <= BUSY;
                        busy    <= 1'b1;
                        winner  <= pick;
                        cnt     <= '0;
                        abort   <= 1'b0;
                        read    <= ~we_i[pick];
                        write   <= we_i[pick];
                        address <= addr_i[pick*ADDR_W +: ADDR_W];
                        data    <= wdata_i[pick*DATA_W +: DATA_W];
                    end
                end
                BUSY: begin
                    if (ack) begin
                        rdata_o   <= write ? '0 : dataOut;
                        abort     <= 1'b0;
                        timeout_o <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata_o   <= '0;
                        abort     <= 1'b1;
                        timeout_o <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (ack || tmo_hit) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        read   <= 1'b0;
                        write  <= 1'b0;
                        done_o <= NUM_CH'(1) << winner;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done_o    <= '0;
                    timeout_o <= 1'b0;
                    abort     <= 1'b0;
                    rr_ptr    <= (winner == LAST_CH) ? '0 : winner + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    read  <= 1'b0;
                    write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t03_mem_arbiter.sv
// Directed and randomized checks of t03_mem_arbiter against a
// transaction-level model (round-robin pointer, ack/timeout timing).
module tb_t03_mem_arbiter;

    localparam int NCH = 3;
    localparam int TMO = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   req_i;
    logic [NCH-1:0]   we_i;
    logic [NCH*32-1:0] addr_i;
    logic [NCH*32-1:0] wdata_i;
    logic             ack;
    logic [31:0]      dataOut;
    logic             read;
    logic             write;
    logic [31:0]      address;
    logic [31:0]      data;
    logic [NCH-1:0]   done_o;
    logic [31:0]      rdata_o;
    logic [NCH-1:0]   stall_o;
    logic             timeout_o;
    logic             busy;

    logic [31:0] addr [NCH];
    logic [31:0] wdat [NCH];

    int          n_chk = 0;
    int          n_fail = 0;
    int          ptr = 0;
    logic [31:0] exp_rd = '0;

    assign addr_i  = {addr[2], addr[1], addr[0]};
    assign wdata_i = {wdat[2], wdat[1], wdat[0]};

    always #5 clk = ~clk;

    t03_mem_arbiter #(
        .NUM_CH(NCH),
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .ack(ack),
        .dataOut(dataOut),
        .read(read),
        .write(write),
        .address(address),
        .data(data),
        .done_o(done_o),
        .rdata_o(rdata_o),
        .stall_o(stall_o),
        .timeout_o(timeout_o),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it idle again.
    // d = BUSY cycle index carrying ack; d >= TMO means ack never comes.
    task automatic txn(input logic [2:0] rq, input logic [2:0] wv,
                       input int d, input logic [31:0] rd);
        int          w;
        int          nb;
        bit          tmo;
        logic        wl;
        logic [31:0] al;
        logic [31:0] dl;
        logic [2:0]  oh;
        w = -1;
        for (int k = 0; k < NCH; k++)
            if (w < 0 && rq[(ptr + k) % NCH]) w = (ptr + k) % NCH;
        req_i = rq;
        we_i  = wv;
        wl    = wv[w];
        al    = addr[w];
        dl    = wdat[w];
        oh    = 3'b001 << w;
        tmo   = (d >= TMO);
        nb    = tmo ? TMO : d + 1;
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_done", {61'd0, done_o}, 64'd0);
        check("idle_rw", {62'd0, read, write}, 64'd0);
        check("rdata_hold", {32'd0, rdata_o}, {32'd0, exp_rd});
        for (int c = 0; c < nb; c++) begin
            @(negedge clk);
            if (c > 0) begin
                for (int i = 0; i < NCH; i++) begin
                    addr[i] = $urandom;
                    wdat[i] = $urandom;
                end
                we_i = 3'($urandom);
                if ($urandom_range(0, 3) == 0) req_i[w] = 1'b0;
            end
            #1;
            check("busy", {63'd0, busy}, 64'd1);
            check("rw", {62'd0, read, write}, {62'd0, ~wl, wl});
            check("address", {32'd0, address}, {32'd0, al});
            check("data", {32'd0, data}, {32'd0, dl});
            check("stall_busy", {61'd0, stall_o}, {61'd0, req_i});
            check("busy_done", {61'd0, done_o}, 64'd0);
            ack     = (c == d);
            dataOut = (c == d) ? rd : $urandom;
        end
        @(negedge clk);
        ack = 1'b0;
        #1;
        exp_rd = (wl || tmo) ? 32'd0 : rd;
        check("done", {61'd0, done_o}, {61'd0, oh});
        check("timeout", {63'd0, timeout_o}, {63'd0, tmo});
        check("rdata", {32'd0, rdata_o}, {32'd0, exp_rd});
        check("done_rw", {62'd0, read, write}, 64'd0);
        check("done_busy", {63'd0, busy}, 64'd0);
        check("addr_hold", {32'd0, address}, {32'd0, al});
        check("data_hold", {32'd0, data}, {32'd0, dl});
        check("stall_done", {61'd0, stall_o}, {61'd0, req_i & ~oh});
        ptr = (w + 1) % NCH;
        @(posedge clk);
        #1;
        req_i = '0;
    endtask

    initial begin
        rst     = 1'b0;
        req_i   = '0;
        we_i    = '0;
        ack     = 1'b0;
        dataOut = '0;
        for (int i = 0; i < NCH; i++) begin
            addr[i] = 32'h1000 + i;
            wdat[i] = 32'hA000 + i;
        end
        repeat (2) @(negedge clk);
        check("rst_rw", {62'd0, read, write}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_addr", {32'd0, address}, 64'd0);
        check("rst_data", {32'd0, data}, 64'd0);
        check("rst_done", {61'd0, done_o}, 64'd0);
        check("rst_rdata", {32'd0, rdata_o}, 64'd0);
        check("rst_tmo", {63'd0, timeout_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Stray ack with no transaction must do nothing.
        ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_busy", {63'd0, busy}, 64'd0);
            check("stray_done", {61'd0, done_o}, 64'd0);
            check("stray_rw", {62'd0, read, write}, 64'd0);
        end
        ack = 1'b0;
        @(posedge clk);
        #1;

        addr[1] = 32'h100;
        txn(3'b010, 3'b000, 3, 32'hDEADBEEF);

        addr[2] = 32'h40;
        wdat[2] = 32'h12345678;
        txn(3'b100, 3'b100, 0, 32'h55AA55AA);

        repeat (6) txn(3'b111, 3'($urandom), 0, $urandom);

        txn(3'b001, 3'b000, 99, 32'hCAFEF00D);
        txn(3'b011, 3'b000, TMO - 1, 32'h0BADC0DE);

        // Reset in the middle of a BUSY read on channel 2.
        req_i = 3'b100;
        we_i  = 3'b000;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_read", {63'd0, read}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_read", {63'd0, read}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_addr", {32'd0, address}, 64'd0);
        @(negedge clk);
        check("arst_done", {61'd0, done_o}, 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        req_i  = '0;
        ptr    = 0;
        exp_rd = '0;
        txn(3'b111, 3'b000, 1, 32'h13579BDF);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NCH; i++) begin
                addr[i] = $urandom;
                wdat[i] = $urandom;
            end
            txn(3'($urandom_range(1, 7)), 3'($urandom),
                int'($urandom_range(0, TMO + 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/t03_mem_arbiter.md
T03_MEM_ARBITER -- requirements
Module: t03_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requester channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter DATA_W, default 32, memory data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max BUSY cycles awaiting ack; 0 disables timeout.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 SHALL have port req_i  input  NUM_CH  per-channel request level, held until that channel's done.
REQ-008 SHALL have port we_i  input  NUM_CH  per-channel write enable (1 write, 0 read).
REQ-009 SHALL have port addr_i  input  NUM_CH*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port wdata_i  input  NUM_CH*DATA_W  per-channel write data, same packing.
REQ-011 SHALL have port ack  input  1  memory completion strobe.
REQ-012 SHALL have port dataOut  input  DATA_W  memory read data, valid with ack.
REQ-013 SHALL have port read  output  1  memory read strobe.
REQ-014 SHALL have port write  output  1  memory write strobe.
REQ-015 SHALL have port address  output  ADDR_W  memory address.
REQ-016 SHALL have port data  output  DATA_W  memory write data.
REQ-017 SHALL have port done_o  output  NUM_CH  one-hot, one-cycle completion pulse.
REQ-018 SHALL have port rdata_o  output  DATA_W  read data returned to completed channel.
REQ-019 SHALL have port stall_o  output  NUM_CH  per-channel freeze: req_i[i] & ~done_o[i] (combinational).
REQ-020 SHALL have port timeout_o  output  1  one-cycle pulse coincident with an aborted done_o.
REQ-021 SHALL have port busy  output  1  high while state is BUSY.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-023 IDLE: if any eligible req_i, SHALL select winner by round-robin from pointer rr_ptr (search rr_ptr, rr_ptr+1, ... wrapping mod NUM_CH), latch winner index, we, addr, wdata, go BUSY; else stay IDLE.
REQ-024 BUSY: read = ~we_lat, write = we_lat, address/data = latched values, all stable for entire BUSY; read and write never both 1.
REQ-025 BUSY with ack=1: SHALL capture dataOut (reads) or 0 (writes) into rdata_o, go DONE.
REQ-026 BUSY, TIMEOUT>0, cycle counter reaching TIMEOUT without ack: SHALL set rdata_o=0, flag abort, go DONE.
REQ-027 DONE (exactly one cycle): done_o[winner]=1, timeout_o=abort flag, read=write=0, rr_ptr <= (winner+1) mod NUM_CH, go IDLE.
REQ-028 Outside BUSY, read, write SHALL be 0; address, data hold last latched values.
REQ-029 rdata_o SHALL hold its value until the next DONE.
REQ-030 Minimum latency: req sampled in IDLE cycle N, strobe in N+1, ack in N+1 gives done_o in N+2.
REQ-031 ack outside BUSY SHALL be ignored; ack coincident with timeout terminal count counts as ack (no timeout).
REQ-032 req_i deasserted mid-BUSY SHALL NOT abort; transaction completes and done_o still pulses.
REQ-033 Changes to addr_i/wdata_i/we_i after latching SHALL NOT affect the current transaction.
REQ-034 Cycle counter SHALL clear on entry to BUSY; width ceil(log2(TIMEOUT+1)), no wrap.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, rr_ptr=0, counter=0, read=write=0, address=0, data=0, done_o=0, rdata_o=0, timeout_o=0, busy=0.
REQ-036 Reset mid-BUSY SHALL abandon transaction without done_o; first arbitration after release starts at channel 0.

Verification
REQ-037 Single read: ch1 req, we=0, addr=0x100; ack with dataOut=0xDEADBEEF 3 cycles later -> read=1 with address=0x100 for those cycles, done_o=3'b010, rdata_o=0xDEADBEEF next cycle.
REQ-038 Round-robin: NUM_CH=3, all req held high -> grant order 0,1,2,0,1,2; no channel granted twice consecutively.
REQ-039 Write: ch2 we=1, addr=0x40, wdata=0x12345678, ack immediate -> write=1, data=0x12345678 one cycle, done_o=3'b100, rdata_o=0.
REQ-040 Timeout: TIMEOUT=4, ack never -> read high 4 cycles, then done_o and timeout_o pulse together, rdata_o=0, next request proceeds.
REQ-041 Reset mid-BUSY: rst=0 during BUSY -> read=0 asynchronously, no done_o; after release ch0 wins first.
REQ-042 stall_o: ch0 req high -> stall_o[0]=1 every cycle until done_o[0] cycle, where stall_o[0]=0.
